// File: rtl/serial_receiver.sv
// serial_receiver: UART-style receiver (start, LSB-first data, stop) with mid-bit sampling.
module serial_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] inputdata,
  output logic                  inputdata_ready,
  output logic                  framing_error
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] MID = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] ILAST = IW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [DATA_WIDTH-1:0]   shift, shift_n, data_n;
  logic                    rdy_n, err_n, rx_m, rx_s;
  // Synchronizer resets high so a released reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m            <= 1'b1;
      rx_s            <= 1'b1;
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      shift           <= '0;
      inputdata       <= '0;
      inputdata_ready <= 1'b0;
      framing_error   <= 1'b0;
    end else begin
      rx_m            <= rx;
      rx_s            <= rx_m;
      state           <= state_n;
      cnt             <= cnt_n;
      idx             <= idx_n;
      shift           <= shift_n;
      inputdata       <= data_n;
      inputdata_ready <= rdy_n;
      framing_error   <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    data_n  = inputdata;
    rdy_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (cnt == MID) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n   = '0;
        shift_n = {rx_s, shift[DATA_WIDTH-1:1]};
        idx_n   = (idx == ILAST) ? '0 : idx + 1'b1;
        state_n = (idx == ILAST) ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        cnt_n   = '0;
        rdy_n   = rx_s;
        err_n   = !rx_s;
        data_n  = rx_s ? shift : inputdata;
        state_n = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : WAIT_IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed frames against serial_receiver at 8 clocks per bit.
module tb_serial_receiver;
  localparam int CPB = 8;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] inputdata;
  logic       inputdata_ready, framing_error;
  int tests = 0, failed = 0;
  int cyc = 0, fall_cyc = 0, rdy_cnt = 0, err_cnt = 0;
  logic [7:0] words[$];
  int rdy_cycs[$];
  logic rdy_q = 1'b0, err_q = 1'b0, rst_s;
  logic [7:0] data_q;
  serial_receiver #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .rx(rx), .inputdata(inputdata),
    .inputdata_ready(inputdata_ready), .framing_error(framing_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    rst_s = reset;
    #1;
    if (inputdata_ready && framing_error) begin
      tests++; failed++;
      $display("FAIL both_pulses at cycle %0d: ready=1 error=1, required not both", cyc);
    end
    if (inputdata_ready) begin
      rdy_cnt++;
      words.push_back(inputdata);
      rdy_cycs.push_back(cyc);
      tests++;
      assert (cyc - fall_cyc == 78)
      else begin
        failed++;
        $display("FAIL ready_latency: got %0d cycles, required 78", cyc - fall_cyc);
      end
      if (rdy_q) begin
        tests++; failed++;
        $display("FAIL ready_width at cycle %0d: high 2+ cycles, required 1", cyc);
      end
    end
    if (framing_error) begin
      err_cnt++;
      if (err_q) begin
        tests++; failed++;
        $display("FAIL error_width at cycle %0d: high 2+ cycles, required 1", cyc);
      end
    end
    if (!inputdata_ready && !rst_s && inputdata !== data_q) begin
      tests++; failed++;
      $display("FAIL data_hold at cycle %0d: got %h, required %h", cyc, inputdata, data_q);
    end
    data_q = inputdata;
    rdy_q  = inputdata_ready;
    err_q  = framing_error;
  end
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    fall_cyc = cyc + 1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests += 3;
    if (inputdata !== 8'h00) begin failed++; $display("FAIL reset_data: got %h, required 00", inputdata); end
    if (inputdata_ready !== 1'b0) begin failed++; $display("FAIL reset_ready: got %b, required 0", inputdata_ready); end
    if (framing_error !== 1'b0) begin failed++; $display("FAIL reset_error: got %b, required 0", framing_error); end
    reset = 1'b0;
    idle(10);
    tests++;
    if (rdy_cnt + err_cnt !== 0) begin failed++; $display("FAIL reset_release_pulses: got %0d, required 0", rdy_cnt + err_cnt); end
  endtask
  task automatic test_single;
    send_frame(8'hA5, 1'b1);
    idle(4);
    tests += 3;
    if (rdy_cnt !== 1) begin failed++; $display("FAIL single_count: got %0d, required 1", rdy_cnt); end
    if (inputdata !== 8'hA5) begin failed++; $display("FAIL single_data: got %h, required a5", inputdata); end
    if (err_cnt !== 0) begin failed++; $display("FAIL single_error: got %0d, required 0", err_cnt); end
  endtask
  task automatic test_back_to_back;
    int r0 = rdy_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    tests++;
    if (rdy_cnt !== r0 + 2) begin
      failed++; $display("FAIL b2b_count: got %0d, required %0d", rdy_cnt - r0, 2);
    end else begin
      tests += 3;
      if (words[r0] !== 8'h00) begin failed++; $display("FAIL b2b_first: got %h, required 00", words[r0]); end
      if (words[r0+1] !== 8'hFF) begin failed++; $display("FAIL b2b_second: got %h, required ff", words[r0+1]); end
      if (rdy_cycs[r0+1] - rdy_cycs[r0] !== 80) begin
        failed++; $display("FAIL b2b_gap: got %0d, required 80", rdy_cycs[r0+1] - rdy_cycs[r0]);
      end
    end
  endtask
  task automatic test_glitch;
    int r0 = rdy_cnt, e0 = err_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(100);
    tests += 2;
    if (rdy_cnt !== r0) begin failed++; $display("FAIL glitch_ready: got %0d pulses, required 0", rdy_cnt - r0); end
    if (err_cnt !== e0) begin failed++; $display("FAIL glitch_error: got %0d pulses, required 0", err_cnt - e0); end
  endtask
  task automatic test_framing;
    int r0, e0;
    send_frame(8'h11, 1'b1);
    idle(4);
    r0 = rdy_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    idle(100);
    tests += 3;
    if (err_cnt !== e0 + 1) begin failed++; $display("FAIL frame_error_count: got %0d, required 1", err_cnt - e0); end
    if (rdy_cnt !== r0) begin failed++; $display("FAIL frame_ready: got %0d pulses, required 0", rdy_cnt - r0); end
    if (inputdata !== 8'h11) begin failed++; $display("FAIL frame_data: got %h, required 11", inputdata); end
  endtask
  task automatic test_reset_mid;
    int r0 = rdy_cnt, e0 = err_cnt;
    logic [7:0] d = 8'h7E;
    fall_cyc = cyc + 1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = d[4];
    repeat (4) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests += 3;
    if (inputdata !== 8'h00) begin failed++; $display("FAIL midreset_data: got %h, required 00", inputdata); end
    if (inputdata_ready !== 1'b0) begin failed++; $display("FAIL midreset_ready: got %b, required 0", inputdata_ready); end
    if (framing_error !== 1'b0) begin failed++; $display("FAIL midreset_error: got %b, required 0", framing_error); end
    idle(100);
    tests++;
    if (rdy_cnt !== r0 || err_cnt !== e0) begin
      failed++; $display("FAIL midreset_pulses: got %0d ready %0d error, required 0 0", rdy_cnt - r0, err_cnt - e0);
    end
    send_frame(8'h81, 1'b1);
    idle(4);
    tests += 2;
    if (rdy_cnt !== r0 + 1) begin failed++; $display("FAIL after_reset_count: got %0d, required 1", rdy_cnt - r0); end
    if (inputdata !== 8'h81) begin failed++; $display("FAIL after_reset_data: got %h, required 81", inputdata); end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200 baud); SHALL be >= 4.
REQ-002 Parameter DATA_WIDTH, default 8, data bits per frame.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 rx  input  1  serial line; idle high; asynchronous to clk.
REQ-006 inputdata  output  DATA_WIDTH  last correctly received word; drives the control unit/datapath load input.
REQ-007 inputdata_ready  output  1  one-cycle pulse when a new valid word is on inputdata; feeds the control unit inputdata_ready.
REQ-008 framing_error  output  1  one-cycle pulse when a frame's stop bit is sampled low.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value (rx_s).
REQ-010 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE; one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..DATA_WIDTH-1).
REQ-011 IDLE: rx_s=0 -> START with counter cleared; otherwise remain.
REQ-012 START: at counter=(CLKS_PER_BIT-1)/2 (mid start bit), rx_s=0 -> DATA with counter and index cleared; rx_s=1 -> IDLE (glitch rejection).
REQ-013 DATA: at counter=CLKS_PER_BIT-1, sample rx_s into shift register, LSB first, clear counter; after bit DATA_WIDTH-1 -> STOP.
REQ-014 STOP: at counter=CLKS_PER_BIT-1, sample rx_s; 1 -> load shift register into inputdata, pulse inputdata_ready, -> IDLE; 0 -> pulse framing_error, inputdata unchanged, -> WAIT_IDLE.
REQ-015 WAIT_IDLE: remain until rx_s=1, then -> IDLE; no start detection in this state.
REQ-016 inputdata_ready and framing_error SHALL be registered, asserted in the cycle after the stop-bit sample edge, high exactly one cycle, never both high.
REQ-017 inputdata SHALL change only in the cycle inputdata_ready rises and hold otherwise.
REQ-018 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss; IDLE detects the new start on the first cycle it sees rx_s=0.
REQ-019 No handshake back-pressure: the consumer SHALL capture inputdata within one frame time; a missed word is overwritten.

Reset
REQ-020 reset=1 at a rising edge SHALL force state IDLE, counter 0, index 0, shift register 0, inputdata 0, inputdata_ready 0, framing_error 0.
REQ-021 Synchronizer flops SHALL reset to 1 so that no start bit is detected after reset release.
REQ-022 reset during any state SHALL abort the frame with no ready or error pulse; reception restarts at the next falling edge of rx.

Verification (CLKS_PER_BIT=8, DATA_WIDTH=8)
REQ-023 Frame 0xA5, stop=1 -> inputdata=0xA5, inputdata_ready high exactly 1 cycle, framing_error never high.
REQ-024 Frames 0x00 then 0xFF with no idle gap -> two ready pulses, 80 cycles apart, values 0x00 then 0xFF.
REQ-025 rx low for 2 cycles then high -> FSM returns to IDLE, no ready, no error.
REQ-026 After valid 0x11, frame 0x3C with stop=0, rx held low 20 cycles -> one framing_error pulse, inputdata stays 0x11, no start detected until rx high.
REQ-027 reset for 1 cycle in mid DATA of frame 0x7E -> all outputs 0 next cycle, no pulses; following frame 0x81 -> inputdata=0x81 with one ready pulse.
REQ-028 Ready pulse timing: measured from rx falling edge, inputdata_ready SHALL rise 2+3+8*8+8+1 = 78 cycles later (+/-0), checked with an assertion.
